alu_control_unit: RTL and testbench

//  - ALU control decoder for the single-cycle MIPS datapath; sits between the main control unit and the ALU.
//  - Turns the 4-bit ALUop from main control plus the 6-bit R-type funct field into the 4-bit ALU operation code.
//  - Output is registered, with one clock; reset is asynchronous and active-low.

---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/alu_ctrl_decode.sv | 38 +++
 rtl/alu_control_unit.sv | 30 +++
 tb/tb_alu_control_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU operation codes, R-type funct encodings and the R-type escape op.
package alu_ctrl_pkg;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0100;
   localparam logic [3:0] ALU_MULA = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_ADDU = 4'b1000;
   localparam logic [3:0] ALU_SUBU = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_LUI  = 4'b1110;

   localparam logic [5:0] SLLFunc  = 6'b000000;
   localparam logic [5:0] SRLFunc  = 6'b000010;
   localparam logic [5:0] SRAFunc  = 6'b000011;
   localparam logic [5:0] ADDFunc  = 6'b100000;
   localparam logic [5:0] ADDUFunc = 6'b100001;
   localparam logic [5:0] SUBFunc  = 6'b100010;
   localparam logic [5:0] SUBUFunc = 6'b100011;
   localparam logic [5:0] ANDFunc  = 6'b100100;
   localparam logic [5:0] ORFunc   = 6'b100101;
   localparam logic [5:0] XORFunc  = 6'b100110;
   localparam logic [5:0] NORFunc  = 6'b100111;
   localparam logic [5:0] SLTFunc  = 6'b101010;
   localparam logic [5:0] SLTUFunc = 6'b101011;
   localparam logic [5:0] MULAFunc = 6'b111000;

   localparam logic [3:0] ALUOP_RTYPE = 4'b1111;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational {ALUop,FuncCode} -> {ALUCtrl_next,IllegalFn_next}.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [3:0] ALUop,
   input  logic [5:0] FuncCode,
   output logic [3:0] ALUCtrl_next,
   output logic       IllegalFn_next
);
   logic [3:0] r_ctrl;
   logic       r_ill;

   always_comb begin
      r_ctrl = ALU_ADD;
      r_ill  = 1'b0;
      case (FuncCode)
         SLLFunc:  r_ctrl = ALU_SLL;
         SRLFunc:  r_ctrl = ALU_SRL;
         SRAFunc:  r_ctrl = ALU_SRA;
         ADDFunc:  r_ctrl = ALU_ADD;
         ADDUFunc: r_ctrl = ALU_ADDU;
         SUBFunc:  r_ctrl = ALU_SUB;
         SUBUFunc: r_ctrl = ALU_SUBU;
         ANDFunc:  r_ctrl = ALU_AND;
         ORFunc:   r_ctrl = ALU_OR;
         XORFunc:  r_ctrl = ALU_XOR;
         NORFunc:  r_ctrl = ALU_NOR;
         SLTFunc:  r_ctrl = ALU_SLT;
         SLTUFunc: r_ctrl = ALU_SLTU;
         MULAFunc: r_ctrl = ALU_MULA;
         default:  r_ill  = 1'b1;
      endcase
   end

   // Non-R-type ops select ALUop directly so an undriven funct field never leaks through.
   assign ALUCtrl_next   = (ALUop == ALUOP_RTYPE) ? r_ctrl : ALUop;
   assign IllegalFn_next = (ALUop == ALUOP_RTYPE) ? r_ill  : 1'b0;
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: registered ALU control decoder between main control and the ALU.
module alu_control_unit
   import alu_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       Reset_L,
   input  logic [3:0] ALUop,
   input  logic [5:0] FuncCode,
   output logic [3:0] ALUCtrl,
   output logic       IllegalFn
);
   logic [3:0] ctrl_next;
   logic       ill_next;

   alu_ctrl_decode u_decode (
      .ALUop          (ALUop),
      .FuncCode       (FuncCode),
      .ALUCtrl_next   (ctrl_next),
      .IllegalFn_next (ill_next)
   );

   always_ff @(posedge CLK or negedge Reset_L)
      if (!Reset_L) begin
         ALUCtrl   <= ALU_AND;
         IllegalFn <= 1'b0;
      end else begin
         ALUCtrl   <= ctrl_next;
         IllegalFn <= ill_next;
      end
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: randomized self-checking bench against a table-driven reference model.
module tb_alu_control_unit;
   logic       CLK = 1'b0;
   logic       Reset_L = 1'b1;
   logic [3:0] ALUop = 4'b0110;
   logic [5:0] FuncCode = 6'b000000;
   logic [3:0] ALUCtrl;
   logic       IllegalFn;

   int passed = 0;
   int total  = 0;
   logic [3:0] fmap [bit [5:0]];
   bit   [5:0] flist [$];

   alu_control_unit dut (
      .CLK       (CLK),
      .Reset_L   (Reset_L),
      .ALUop     (ALUop),
      .FuncCode  (FuncCode),
      .ALUCtrl   (ALUCtrl),
      .IllegalFn (IllegalFn)
   );

   always #5 CLK = ~CLK;

   // Reference: pass-through unless R-type; R-type looks up the funct table, misses give ADD+illegal.
   function automatic logic [4:0] model(input logic [3:0] op, input logic [5:0] fn);
      if (op !== 4'hF) return {op, 1'b0};
      if ($isunknown(fn)) return {4'h2, 1'b1};
      if (fmap.exists(fn)) return {fmap[fn], 1'b0};
      return {4'h2, 1'b1};
   endfunction

   task automatic edge1();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      #2 Reset_L = 1'b0;
      #1;
      total++;
      if ({ALUCtrl, IllegalFn} !== 5'b00000)
         $display("FAIL reset_async: got %b/%b want 0000/0", ALUCtrl, IllegalFn);
      else passed++;
      edge1();
      total++;
      if ({ALUCtrl, IllegalFn} !== 5'b00000)
         $display("FAIL reset_hold: got %b/%b want 0000/0", ALUCtrl, IllegalFn);
      else passed++;
      #3 Reset_L = 1'b1;
      edge1();
      total++;
      if ({ALUCtrl, IllegalFn} !== 5'b01100)
         $display("FAIL reset_release: got %b/%b want 0110/0", ALUCtrl, IllegalFn);
      else passed++;
   endtask

   task automatic test_rtype_sweep();
      bit [5:0] q [$];
      logic [4:0] e;
      q = flist;
      q.shuffle();
      foreach (q[i]) begin
         ALUop = 4'hF;
         FuncCode = q[i];
         e = model(ALUop, FuncCode);
         edge1();
         total++;
         if ({ALUCtrl, IllegalFn} !== e)
            $display("FAIL rtype_%b: got %b/%b want %b/%b", q[i], ALUCtrl, IllegalFn, e[4:1], e[0]);
         else passed++;
      end
   endtask

   task automatic test_passthrough();
      logic [3:0] ops [11] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
      foreach (ops[i]) begin
         ALUop = ops[i];
         FuncCode = 6'bxxxxxx;
         edge1();
         total++;
         if ($isunknown({ALUCtrl, IllegalFn}) || ALUCtrl !== ops[i] || IllegalFn !== 1'b0)
            $display("FAIL pass_%b: got %b/%b want %b/0", ops[i], ALUCtrl, IllegalFn, ops[i]);
         else passed++;
      end
      FuncCode = 6'b000000;
   endtask

   task automatic test_illegal();
      ALUop = 4'hF;
      FuncCode = 6'b001000;
      edge1();
      total++;
      if ({ALUCtrl, IllegalFn} !== 5'b00101)
         $display("FAIL illegal_fn: got %b/%b want 0010/1", ALUCtrl, IllegalFn);
      else passed++;
      FuncCode = 6'b100100;
      edge1();
      total++;
      if ({ALUCtrl, IllegalFn} !== 5'b00000)
         $display("FAIL illegal_recover: got %b/%b want 0000/0", ALUCtrl, IllegalFn);
      else passed++;
   endtask

   task automatic test_latency();
      for (int i = 0; i < 12; i++) begin
         ALUop = i[0] ? 4'hF : 4'h1;
         FuncCode = i[0] ? 6'b100110 : 6'b000000;
         edge1();
         total++;
         if (ALUCtrl !== (i[0] ? 4'b1010 : 4'b0001) || IllegalFn !== 1'b0)
            $display("FAIL latency_%0d: got %b/%b want %b/0", i, ALUCtrl, IllegalFn, i[0] ? 4'b1010 : 4'b0001);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] e;
      for (int i = 0; i < 200; i++) begin
         ALUop = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
         FuncCode = ($urandom_range(0, 1) == 1) ? flist[$urandom_range(0, flist.size() - 1)]
                                                : 6'($urandom_range(0, 63));
         e = model(ALUop, FuncCode);
         edge1();
         total++;
         if ({ALUCtrl, IllegalFn} !== e)
            $display("FAIL random_%0d op=%b fn=%b: got %b/%b want %b/%b", i, ALUop, FuncCode,
                     ALUCtrl, IllegalFn, e[4:1], e[0]);
         else passed++;
      end
   endtask

   task automatic test_mid_reset();
      ALUop = 4'hC;
      edge1();
      total++;
      if (ALUCtrl !== 4'b1100)
         $display("FAIL midrst_pre: got %b want 1100", ALUCtrl);
      else passed++;
      #2 Reset_L = 1'b0;
      #1;
      total++;
      if ({ALUCtrl, IllegalFn} !== 5'b00000)
         $display("FAIL midrst_async: got %b/%b want 0000/0", ALUCtrl, IllegalFn);
      else passed++;
      ALUop = 4'hF;
      FuncCode = 6'b101011;
      #1 Reset_L = 1'b1;
      edge1();
      total++;
      if ({ALUCtrl, IllegalFn} !== 5'b10110)
         $display("FAIL midrst_release: got %b/%b want 1011/0", ALUCtrl, IllegalFn);
      else passed++;
   endtask

   initial begin
      fmap[6'b000000] = 4'b0011; fmap[6'b000010] = 4'b0100; fmap[6'b000011] = 4'b1101;
      fmap[6'b100000] = 4'b0010; fmap[6'b100001] = 4'b1000; fmap[6'b100010] = 4'b0110;
      fmap[6'b100011] = 4'b1001; fmap[6'b100100] = 4'b0000; fmap[6'b100101] = 4'b0001;
      fmap[6'b100110] = 4'b1010; fmap[6'b100111] = 4'b1100; fmap[6'b101010] = 4'b0111;
      fmap[6'b101011] = 4'b1011; fmap[6'b111000] = 4'b0101;
      foreach (fmap[k]) flist.push_back(k);
      test_reset();
      test_rtype_sweep();
      test_passthrough();
      test_illegal();
      test_latency();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
